// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin arbiter sharing one 8x8 unsigned multiplier
// among NUM_REQ requesters. The multiplier runs in a two-register pipeline
// and returns the tagged product on a single valid/ready response port.
module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [15:0]          rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    localparam int DATA_W = 8;
    localparam int PROD_W = 2 * DATA_W;

    // Full-width unsigned product; no truncation is possible at 2*DATA_W bits.
    function automatic logic [PROD_W-1:0] fp_mul(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    endfunction

    logic                 adv;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      ptr_nxt;
    logic [ID_W-1:0]      cand;
    logic                 vld_p0;
    logic [ID_W-1:0]      id_p0;
    logic [DATA_W-1:0]    a_p0;
    logic [DATA_W-1:0]    b_p0;

    logic                 vld_p1;
    logic [ID_W-1:0]      id_p1;
    logic [DATA_W-1:0]    a_p1;
    logic [DATA_W-1:0]    b_p1;

    logic                 vld_p2;
    logic [ID_W-1:0]      id_p2;
    logic [PROD_W-1:0]    prod_p2;

    // The whole pipeline moves only when the output register is free or drained.
    assign adv = ~vld_p2 | rsp_ready;

    // ---- stage p0: arbitration and operand select (combinational) ----

    // Scan from ptr downward in priority so the first valid index after ptr wins.
    always_comb begin
        vld_p0 = 1'b0;
        id_p0  = '0;
        cand   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                vld_p0 = 1'b1;
                id_p0  = cand;
            end
        end
    end

    // Mux the granted requester's operands and form the one-hot ready.
    always_comb begin
        a_p0      = '0;
        b_p0      = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (id_p0 == ID_W'(i)) begin
                a_p0 = req_a[DATA_W*i +: DATA_W];
                b_p0 = req_b[DATA_W*i +: DATA_W];
                req_ready[i] = vld_p0 & adv;
            end
        end
    end

    assign ptr_nxt = (id_p0 == ID_W'(NUM_REQ - 1)) ? '0 : id_p0 + ID_W'(1);

    // ---- stage p1: registered operands ----

    // Control: pointer and valid bits, frozen whenever adv is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (adv) begin
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            if (vld_p0) begin
                ptr <= ptr_nxt;
            end
        end
    end

    // Operand capture only on an actual accept; holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_p1  <= '0;
            b_p1  <= '0;
            id_p1 <= '0;
        end else if (adv && vld_p0) begin
            a_p1  <= a_p0;
            b_p1  <= b_p0;
            id_p1 <= id_p0;
        end
    end

    // ---- stage p2: registered product driving the response port ----

    // Product and tag load whenever the pipeline advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p2 <= '0;
            id_p2   <= '0;
        end else if (adv) begin
            prod_p2 <= fp_mul(a_p1, b_p1);
            id_p2   <= id_p1;
        end
    end

    assign rsp_valid = vld_p2;
    assign rsp_data  = prod_p2;
    assign rsp_id    = id_p2;
    assign busy      = vld_p1 | vld_p2;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed self-checking bench for fp_mul_arbiter (NUM_REQ = 4).
module tb_fp_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [15:0]          rsp_data;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;

    fp_mul_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        step();
        step();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_id, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got rdy=%b v=%b d=%h id=%0d busy=%b, want all 0",
                     req_ready, rsp_valid, rsp_data, rsp_id, busy);
        end
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_id, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b v=%b d=%h id=%0d busy=%b, want all 0",
                     req_ready, rsp_valid, rsp_data, rsp_id, busy);
        end
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        step();
        step();
    endtask

    task automatic test_single();
        do_reset();
        set_lane(2, 8'hFF, 8'hFF);
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_stage1: got v=%b busy=%b want v=0 busy=1", rsp_valid, busy);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'hFE01 || rsp_id !== 2'd2) begin
            n_fail++;
            $display("FAIL single_rsp: got v=%b d=%h id=%0d want v=1 d=fe01 id=2",
                     rsp_valid, rsp_data, rsp_id);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [15:0] exp_d   [5] = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd3};
        logic [1:0]  exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 8'(i + 1), 8'd3);
        for (int k = 0; k < 6; k++) begin
            req_valid = (k < 5) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 5) begin
                n_checks++;
                if (req_ready !== exp_rdy[k]) begin
                    n_fail++;
                    $display("FAIL rr_grant k=%0d: got %b want %b", k, req_ready, exp_rdy[k]);
                end
            end
            step();
            if (k >= 1) begin
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_data !== exp_d[k-1] || rsp_id !== exp_id[k-1]) begin
                    n_fail++;
                    $display("FAIL rr_rsp k=%0d: got v=%b d=%0d id=%0d want v=1 d=%0d id=%0d",
                             k, rsp_valid, rsp_data, rsp_id, exp_d[k-1], exp_id[k-1]);
                end
            end
        end
        step();
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 8'(8'h10 + i), 8'(i + 2));
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_fill0: got %b want 0001", req_ready);
        end
        step();
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_fill1: got %b want 0010", req_ready);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0020 || rsp_id !== 2'd0) begin
            n_fail++;
            $display("FAIL bp_first: got v=%b d=%h id=%0d want v=1 d=0020 id=0",
                     rsp_valid, rsp_data, rsp_id);
        end
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_ready c=%0d: got %b want 0000", c, req_ready);
            end
            step();
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 16'h0020 || rsp_id !== 2'd0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold c=%0d: got v=%b d=%h id=%0d busy=%b want v=1 d=0020 id=0 busy=1",
                         c, rsp_valid, rsp_data, rsp_id, busy);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_resume_grant: got %b want 0100", req_ready);
        end
        step();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0033 || rsp_id !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_second: got v=%b d=%h id=%0d want v=1 d=0033 id=1",
                     rsp_valid, rsp_data, rsp_id);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'h0048 || rsp_id !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_third: got v=%b d=%h id=%0d want v=1 d=0048 id=2",
                     rsp_valid, rsp_data, rsp_id);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got v=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_sparse();
        do_reset();
        rsp_ready = 1'b1;
        set_lane(1, 8'd2, 8'd2);
        req_valid = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL sparse_setup: got %b want 0010", req_ready);
        end
        step();
        // ptr is now 2: requesters 1 and 3 valid -> 3 wins
        set_lane(1, 8'd0, 8'h7F);
        set_lane(3, 8'd5, 8'd7);
        req_valid = 4'b1010;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL sparse_grant3: got %b want 1000", req_ready);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'd4 || rsp_id !== 2'd1) begin
            n_fail++;
            $display("FAIL sparse_rsp_a: got v=%b d=%0d id=%0d want v=1 d=4 id=1",
                     rsp_valid, rsp_data, rsp_id);
        end
        // requester 3 drops; pointer wrapped to 0, requester 0 idle -> 1 wins
        req_valid = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL sparse_grant1: got %b want 0010", req_ready);
        end
        step();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'd35 || rsp_id !== 2'd3) begin
            n_fail++;
            $display("FAIL sparse_rsp_b: got v=%b d=%0d id=%0d want v=1 d=35 id=3",
                     rsp_valid, rsp_data, rsp_id);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 16'd0 || rsp_id !== 2'd1) begin
            n_fail++;
            $display("FAIL sparse_zero: got v=%b d=%0d id=%0d want v=1 d=0 id=1",
                     rsp_valid, rsp_data, rsp_id);
        end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_lane(i, 8'(i + 9), 8'd11);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        step();
        step();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_inflight: got v=%b busy=%b want 1 1", rsp_valid, busy);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_async: got v=%b busy=%b d=%h want 0 0 0000", rsp_valid, busy, rsp_data);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_stale c=%0d: got v=%b busy=%b want 0 0", c, rsp_valid, busy);
            end
        end
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_ptr_cleared: got %b want 0001", req_ready);
        end
        step();
        req_valid = '0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_sparse();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
